imem_line_buffer: RTL and testbench
===================================

// Module: imem_line_buffer
// PURPOSE
//  Instruction-memory responder for the fetch stage: takes fetch address pcF, returns instrF.
//  Holds one line of LINE_WORDS instructions. Hits are served combinationally.
//  On a miss it refills the line from the external instruction bus with a req/ack handshake,
//  one word per handshake, and raises imem_stall to the hazard unit (drives stallF/stallD).
// PARAMETERS
//  LINE_WORDS  4   words per line; power of 2, >= 2
//  IDX_W       2   log2(LINE_WORDS)
//  CNT_W       16  width of the miss counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  pcF         in   32     fetch address; bits [1:0] ignored
//  instrF      out  32     instruction for pcF; 32'h0000_0013 (NOP) whenever imem_stall=1
//  imem_stall  out  1      1 = instrF not valid this cycle; fetch must hold pcF
//  mem_req     out  1      bus read request; held high until mem_ack
//  mem_addr    out  32     word-aligned bus read address; stable while mem_req=1
//  mem_rdata   in   32     bus read data; valid in the cycle mem_ack=1
//  mem_ack     in   1      bus completion; sampled only while mem_req=1
//  miss_count  out  CNT_W  number of line refills started; saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst=1): valid=0, state=IDLE, mem_req=0, mem_addr=0, word counter=0,
//   miss_count=0, line data=0. Outputs: imem_stall=1 (no valid line), instrF=NOP.
//  Address split: tag = pcF[31:2+IDX_W], index = pcF[1+IDX_W:2], base = {tag, IDX_W+2 zero bits}.
//  hit = valid && (tag == stored tag) && state==IDLE.
//   Combinational: instrF = hit ? line[index] : NOP; imem_stall = !hit.
//  FSM states:
//   IDLE:   if !hit, latch base into refill_base, counter=0, mem_req<=1, mem_addr<=base,
//           valid<=0, miss_count++ (saturating). Next state is REFILL.
//   REFILL: mem_req=1. On mem_ack: line[counter]<=mem_rdata.
//           If counter != LINE_WORDS-1: counter++, mem_addr += 4 (next cycle).
//           Else: mem_req<=0, valid<=1, stored tag<=refill_base tag. Next state is IDLE.
//           With no mem_ack, all registers hold.
//  Latency: a miss first seen in cycle N drives mem_req high from N+1. With zero-wait ack
//   (ack in the same cycle as req), the last word is written at the end of cycle N+LINE_WORDS.
//   The hit is in cycle N+LINE_WORDS+1, so the stall lasts LINE_WORDS+1 cycles.
//   Each bus wait cycle adds one stall cycle.
//  Hit in IDLE: no bus activity, imem_stall=0 in the same cycle, no state change.
//  A refill is never aborted. If pcF changes mid-refill (branch redirect), the latched line
//   still completes. The new pcF is then looked up in IDLE and may trigger a second refill.
//  mem_ack while mem_req=0 is ignored.
//  Line crossing: pcF = base + 4*(LINE_WORDS-1) then +4 is a miss -> refill of the next line.
//  Address wrap: base 32'hFFFF_FFF0 refills up to 32'hFFFF_FFFC; mem_addr never wraps inside a line.
//  Reset mid-refill: mem_req drops asynchronously, valid=0, the partial line is discarded.
//  miss_count holds at 2^CNT_W-1 once reached.
// TESTING
//  1. Reset, pcF=0, ack same cycle, rdata=0x100+addr -> mem_addr 0,4,8,C on 4 cycles;
//     stall 5 cycles; then instrF=0x100, stall=0.
//  2. After T1, pcF=4,8,C -> instrF 0x104,0x108,0x10C with no stall and mem_req=0;
//     pcF=0x10 -> miss, mem_addr=0x10, miss_count=2.
//  3. Wait states: ack 2 cycles after each req -> mem_addr stable while unacked;
//     stall = 1+4*3 = 13 cycles.
//  4. Redirect mid-refill: pcF=0x20 refilling, after 2 acks pcF=0x80 -> 0x20 line completes,
//     then refill at 0x80, miss_count +2.
//  5. Reset asserted after 2 acks -> mem_req=0 immediately, valid=0;
//     after release pcF=0x20 refills from 0x20.
//  6. Spurious mem_ack in IDLE with a hit -> no state change, instrF unchanged;
//     miss_count with CNT_W=2 after 5 misses = 3.

Source files
------------

// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer for the fetch stage: serves hits combinationally and
// refills the whole line over a req/ack bus on a miss, stalling fetch until the line is valid.
module imem_line_buffer #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned IDX_W      = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pcF,
   output logic [31:0]      instrF,
   output logic             imem_stall,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] miss_count
);

   localparam int unsigned   TAG_W = 32 - 2 - IDX_W;
   localparam logic [31:0]   NOP   = 32'h0000_0013;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   typedef enum logic {IDLE, REFILL} state_e;

   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [TAG_W-1:0]    refill_tag_q, refill_tag_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic                req_q, req_d;
   logic [31:0]         addr_q, addr_d;
   logic [CNT_W-1:0]    miss_q, miss_d;
   logic                line_we;
   logic [31:0]         line_q [LINE_WORDS];

   logic [TAG_W-1:0]    pc_tag;
   logic [IDX_W-1:0]    pc_idx;
   logic [31:0]         pc_base;
   logic                hit;
   logic                unused_pc_lsbs;

   assign pc_tag         = pcF[31:2+IDX_W];
   assign pc_idx         = pcF[1+IDX_W:2];
   assign pc_base        = {pc_tag, {(IDX_W+2){1'b0}}};
   assign unused_pc_lsbs = ^pcF[1:0];

   assign hit        = valid_q && (pc_tag == tag_q) && (state_q == IDLE);
   assign instrF     = hit ? line_q[pc_idx] : NOP;
   assign imem_stall = !hit;
   assign mem_req    = req_q;
   assign mem_addr   = addr_q;
   assign miss_count = miss_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!hit) state_d = REFILL;
         REFILL:  if (mem_ack && (cnt_q == LAST_IDX)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values; a refill is never abandoned once started
   always_comb begin
      valid_d      = valid_q;
      tag_d        = tag_q;
      refill_tag_d = refill_tag_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      addr_d       = addr_q;
      miss_d       = miss_q;
      line_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!hit) begin
               refill_tag_d = pc_tag;
               cnt_d        = '0;
               req_d        = 1'b1;
               addr_d       = pc_base;
               valid_d      = 1'b0;
               miss_d       = (miss_q == {CNT_W{1'b1}}) ? miss_q : miss_q + CNT_W'(1);
            end
         end
         REFILL: begin
            if (mem_ack) begin
               line_we = 1'b1;
               if (cnt_q != LAST_IDX) begin
                  cnt_d  = cnt_q + IDX_W'(1);
                  addr_d = addr_q + 32'd4;
               end else begin
                  req_d   = 1'b0;
                  valid_d = 1'b1;
                  tag_d   = refill_tag_q;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         tag_q        <= '0;
         refill_tag_q <= '0;
         cnt_q        <= '0;
         req_q        <= 1'b0;
         addr_q       <= '0;
         miss_q       <= '0;
         for (int unsigned i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
      end else begin
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         refill_tag_q <= refill_tag_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         miss_q       <= miss_d;
         if (line_we) line_q[cnt_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Scoreboard bench for imem_line_buffer: expected bus addresses and instructions are queued
// by the stimulus and popped by monitors when the DUT shows a bus beat or a valid fetch.
module tb_imem_line_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF;
   logic [31:0] instrF, instrF2;
   logic        imem_stall, imem_stall2;
   logic        mem_req, mem_req2;
   logic [31:0] mem_addr, mem_addr2;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] miss_count;
   logic [1:0]  miss_count2;

   int          ack_wait;
   logic        spur_ack;
   int          wcnt;
   int          total = 0;
   int          bad   = 0;

   logic [31:0] addr_q  [$];
   logic [31:0] instr_q [$];
   logic        prev_pend;
   logic [31:0] prev_addr;

   always #5 clk = ~clk;

   imem_line_buffer #(.LINE_WORDS(4), .IDX_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .pcF(pcF), .instrF(instrF), .imem_stall(imem_stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .miss_count(miss_count)
   );

   // Narrow-counter twin sees the same traffic to exercise saturation
   imem_line_buffer #(.LINE_WORDS(4), .IDX_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .pcF(pcF), .instrF(instrF2), .imem_stall(imem_stall2),
      .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .miss_count(miss_count2)
   );

   // Bus model: data = 0x100 + address, ack after ack_wait idle cycles of req
   assign mem_rdata = mem_addr + 32'h100;
   assign mem_ack   = (mem_req && (wcnt == ack_wait)) || spur_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     wcnt <= 0;
      else if (mem_req && mem_ack) wcnt <= 0;
      else if (mem_req)            wcnt <= wcnt + 1;
      else                         wcnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus monitor: each accepted beat must match the next queued address
   always @(negedge clk) begin
      if (mem_req && prev_pend) chk("addr_stable", mem_addr, prev_addr);
      if (mem_req && mem_ack) begin
         if (addr_q.size() > 0) chk("bus_addr", mem_addr, addr_q.pop_front());
         else chk("unexpected_beat", mem_addr, 32'hxxxx_xxxx);
      end
      if (mem_req2 !== mem_req) chk("twin_req", 32'(mem_req2), 32'(mem_req));
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
   end

   // Fetch monitor: each valid cycle checks the next queued instruction
   always @(negedge clk) begin
      if (!imem_stall && instr_q.size() > 0) chk("instrF", instrF, instr_q.pop_front());
   end

   task automatic push_line(input logic [31:0] pc, input int beats);
      logic [31:0] base;
      base = {pc[31:4], 4'b0000};
      for (int i = 0; i < beats; i++) addr_q.push_back(base + 32'(4 * i));
   endtask

   // Present pc until one valid cycle; exp_stall < 0 skips the stall-length check
   task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input int exp_stall,
                        input bit miss);
      int stalls;
      bit done;
      if (miss) push_line(pc, 4);
      instr_q.push_back(exp);
      pcF    = pc;
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (!imem_stall) done = 1'b1;
         else stalls++;
      end
      if (!done) begin
         chk("fetch_timeout", pc, 32'hxxxx_xxxx);
         instr_q.delete();
      end else begin
         if (exp_stall >= 0) chk("stall_cycles", 32'(stalls), 32'(exp_stall));
         if (exp_stall == 0) chk("hit_no_req", 32'(mem_req), 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input int n);
      int seen;
      seen = 0;
      for (int c = 0; c < 100 && seen < n; c++) begin
         @(negedge clk);
         if (mem_req && mem_ack) seen++;
      end
      if (seen < n) chk("beat_timeout", 32'(seen), 32'(n));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pcF = 32'h0; ack_wait = 0; spur_ack = 1'b0;
      prev_pend = 1'b0; prev_addr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall",  32'(imem_stall), 32'd1);
      chk("rst_instr",  instrF, 32'h0000_0013);
      chk("rst_req",    32'(mem_req), 32'd0);
      chk("rst_addr",   mem_addr, 32'h0);
      chk("rst_misses", 32'(miss_count), 32'd0);
      rst = 1'b0;

      // Cold miss on line 0, zero-wait bus
      fetch(32'h0, 32'h100, 5, 1'b1);
      chk("misses_t1", 32'(miss_count), 32'd1);

      // Hits within the line, then crossing into the next line
      fetch(32'h4, 32'h104, 0, 1'b0);
      fetch(32'h8, 32'h108, 0, 1'b0);
      fetch(32'hC, 32'h10C, 0, 1'b0);
      fetch(32'h10, 32'h110, 5, 1'b1);
      chk("misses_t2", 32'(miss_count), 32'd2);

      // Two wait states per beat
      ack_wait = 2;
      fetch(32'h30, 32'h130, 13, 1'b1);
      ack_wait = 0;

      // Top-of-memory line
      fetch(32'hFFFF_FFFC, 32'h0000_00FC, 5, 1'b1);

      // Redirect after two beats: old line completes, then the new one refills
      push_line(32'h20, 4);
      pcF = 32'h20;
      wait_beats(2);
      fetch(32'h80, 32'h180, 7, 1'b1);
      chk("misses_t4", 32'(miss_count), 32'd6);
      chk("sat_t4", 32'(miss_count2), 32'd3);

      // Reset in the middle of a refill
      push_line(32'h20, 2);
      pcF = 32'h20;
      wait_beats(2);
      rst = 1'b1;
      #1;
      chk("midrst_req",   32'(mem_req), 32'd0);
      chk("midrst_stall", 32'(imem_stall), 32'd1);
      chk("midrst_addr",  mem_addr, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      fetch(32'h20, 32'h120, 5, 1'b1);
      chk("misses_t5", 32'(miss_count), 32'd1);

      // Stray ack while idle on a hit
      spur_ack = 1'b1;
      fetch(32'h24, 32'h124, 0, 1'b0);
      fetch(32'h24, 32'h124, 0, 1'b0);
      fetch(32'h2C, 32'h12C, 0, 1'b0);
      spur_ack = 1'b0;
      chk("spur_misses", 32'(miss_count), 32'd1);
      fetch(32'h28, 32'h128, 0, 1'b0);

      // Saturation of the 2-bit counter
      fetch(32'h30, 32'h130, 5, 1'b1);
      chk("sat_two", 32'(miss_count2), 32'd2);
      fetch(32'h40, 32'h140, 5, 1'b1);
      fetch(32'h50, 32'h150, 5, 1'b1);
      fetch(32'h60, 32'h160, 5, 1'b1);
      chk("misses_t6", 32'(miss_count), 32'd5);
      chk("sat_hold",  32'(miss_count2), 32'd3);

      chk("addr_q_left",  32'(addr_q.size()), 32'd0);
      chk("instr_q_left", 32'(instr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
